// File: rtl/nasti_wr_arbiter_pkg.sv
// Shared NASTI write-arbiter definitions: port-tag width, FSM states and the
// round-robin selection helper used by nasti_rr_picker.
package nasti_wr_arbiter_pkg;

  localparam int PORT_TAG_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                  found;
    logic [PORT_TAG_W-1:0] idx;
  } rr_pick_t;

  function automatic rr_pick_t rr_pick(input logic [7:0] req,
                                       input logic [PORT_TAG_W-1:0] ptr);
    rr_pick_t              res;
    logic [PORT_TAG_W-1:0] idx;
    res = '0;
    // Scan farthest-first so the closest request at or after ptr wins.
    for (int k = 7; k >= 0; k--) begin
      idx = ptr + PORT_TAG_W'(k);
      if (req[idx]) begin
        res.found = 1'b1;
        res.idx   = idx;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/nasti_channel.sv
// NASTI channel bundle; every signal is a packed array with one lane per port.
interface nasti_channel #(
  parameter int N_CHAN     = 1,
  parameter int ID_WIDTH   = 1,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int USER_WIDTH = 1
) ();
  localparam int STRB_WIDTH = (DATA_WIDTH + 7) / 8;

  logic [N_CHAN-1:0][ID_WIDTH-1:0]   aw_id;
  logic [N_CHAN-1:0][ADDR_WIDTH-1:0] aw_addr;
  logic [N_CHAN-1:0][7:0]            aw_len;
  logic [N_CHAN-1:0][2:0]            aw_size;
  logic [N_CHAN-1:0][1:0]            aw_burst;
  logic [N_CHAN-1:0]                 aw_lock;
  logic [N_CHAN-1:0][3:0]            aw_cache;
  logic [N_CHAN-1:0][2:0]            aw_prot;
  logic [N_CHAN-1:0][3:0]            aw_qos;
  logic [N_CHAN-1:0][3:0]            aw_region;
  logic [N_CHAN-1:0][USER_WIDTH-1:0] aw_user;
  logic [N_CHAN-1:0]                 aw_valid;
  logic [N_CHAN-1:0]                 aw_ready;

  logic [N_CHAN-1:0][DATA_WIDTH-1:0] w_data;
  logic [N_CHAN-1:0][STRB_WIDTH-1:0] w_strb;
  logic [N_CHAN-1:0]                 w_last;
  logic [N_CHAN-1:0][USER_WIDTH-1:0] w_user;
  logic [N_CHAN-1:0]                 w_valid;
  logic [N_CHAN-1:0]                 w_ready;

  logic [N_CHAN-1:0][ID_WIDTH-1:0]   b_id;
  logic [N_CHAN-1:0][1:0]            b_resp;
  logic [N_CHAN-1:0][USER_WIDTH-1:0] b_user;
  logic [N_CHAN-1:0]                 b_valid;
  logic [N_CHAN-1:0]                 b_ready;

  logic [N_CHAN-1:0][ID_WIDTH-1:0]   ar_id;
  logic [N_CHAN-1:0][ADDR_WIDTH-1:0] ar_addr;
  logic [N_CHAN-1:0][7:0]            ar_len;
  logic [N_CHAN-1:0]                 ar_valid;
  logic [N_CHAN-1:0]                 ar_ready;

  logic [N_CHAN-1:0][ID_WIDTH-1:0]   r_id;
  logic [N_CHAN-1:0][DATA_WIDTH-1:0] r_data;
  logic [N_CHAN-1:0][1:0]            r_resp;
  logic [N_CHAN-1:0]                 r_last;
  logic [N_CHAN-1:0]                 r_valid;
  logic [N_CHAN-1:0]                 r_ready;

  modport master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_valid,
    output r_ready
  );

  modport slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache,
           aw_prot, aw_qos, aw_region, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_valid,
    input  r_ready
  );

endinterface

// File: rtl/nasti_rr_picker.sv
// Combinational round-robin picker: first set request at or after i_ptr.
module nasti_rr_picker
  import nasti_wr_arbiter_pkg::*;
(
  input  logic [7:0] i_req,
  input  logic [2:0] i_ptr,
  output logic [2:0] o_idx,
  output logic       o_found
);

  rr_pick_t w_pick;

  assign w_pick  = rr_pick(i_req, i_ptr);
  assign o_idx   = w_pick.idx;
  assign o_found = w_pick.found;

endmodule

// File: rtl/nasti_wr_arbiter.sv
// Round-robin arbiter serialising NASTI write bursts from N_PORT requesters.
// Optional per-port outstanding limit: define NASTI_WR_ARB_OUTSTANDING_EN.
module nasti_wr_arbiter
  import nasti_wr_arbiter_pkg::*;
#(
  parameter int N_PORT          = 2,
  parameter int ID_WIDTH        = 1,
  parameter int ADDR_WIDTH      = 8,
  parameter int DATA_WIDTH      = 8,
  parameter int USER_WIDTH      = 1,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  nasti_channel.slave           s,
  nasti_channel.master          m,
  output arb_state_e            o_dbg_state,
  output logic [PORT_TAG_W-1:0] o_dbg_grant,
  output logic [PORT_TAG_W-1:0] o_dbg_rr_ptr
);

  localparam int SEL_W = (N_PORT > 1) ? $clog2(N_PORT) : 1;

  // Handshakes: a transfer happens in a cycle where valid && ready; a master
  // holds valid and payload stable until it sees ready, and ready may depend
  // combinationally on valid.

  arb_state_e            r_state;
  arb_state_e            w_state_nxt;
  logic [PORT_TAG_W-1:0] r_grant;
  logic [PORT_TAG_W-1:0] r_rr_ptr;
  logic [SEL_W-1:0]      w_gsel;
  logic [7:0]            w_req;
  logic [PORT_TAG_W-1:0] w_pick_idx;
  logic                  w_pick_found;
  logic                  w_aw_valid;
  logic                  w_w_valid;
  logic                  w_aw_hs;
  logic                  w_w_hs;
  logic [PORT_TAG_W-1:0] w_b_port;
  logic [SEL_W-1:0]      w_b_sel;
  logic                  w_b_hit;
  logic                  w_unused;

  assign w_gsel = r_grant[SEL_W-1:0];

`ifdef NASTI_WR_ARB_OUTSTANDING_EN
  logic [N_PORT-1:0][3:0] r_outst;
  logic [N_PORT-1:0]      w_inc;
  logic [N_PORT-1:0]      w_dec;

  always_comb begin
    w_req = '0;
    w_inc = '0;
    w_dec = '0;
    for (int i = 0; i < N_PORT; i++) begin
      w_req[i] = s.aw_valid[i] && (r_outst[i] != 4'(MAX_OUTSTANDING));
      w_inc[i] = w_aw_hs && (r_grant == PORT_TAG_W'(i));
      w_dec[i] = s.b_valid[i] && s.b_ready[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_outst <= '0;
    end else begin
      for (int i = 0; i < N_PORT; i++) begin
        if (w_inc[i] && !w_dec[i]) begin
          r_outst[i] <= r_outst[i] + 4'd1;
        end else if (w_dec[i] && !w_inc[i] && (r_outst[i] != 4'd0)) begin
          r_outst[i] <= r_outst[i] - 4'd1;
        end
      end
    end
  end
`else
  always_comb begin
    w_req = '0;
    for (int i = 0; i < N_PORT; i++) begin
      w_req[i] = s.aw_valid[i];
    end
  end
`endif

  nasti_rr_picker u_picker (
    .i_req   (w_req),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_pick_idx),
    .o_found (w_pick_found)
  );

  assign w_aw_hs = w_aw_valid && m.aw_ready[0];
  assign w_w_hs  = w_w_valid && m.w_ready[0];

  always_comb begin
    w_state_nxt = r_state;
    w_aw_valid  = 1'b0;
    w_w_valid   = 1'b0;
    unique case (r_state)
      ST_IDLE: if (w_pick_found) w_state_nxt = ST_ADDR;
      ST_ADDR: begin
        w_aw_valid = 1'b1;
        if (m.aw_ready[0]) w_state_nxt = ST_DATA;
      end
      ST_DATA: begin
        w_w_valid = s.w_valid[w_gsel];
        if (w_w_valid && m.w_ready[0] && s.w_last[w_gsel]) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && w_pick_found) r_grant <= w_pick_idx;
      if (w_aw_hs) begin
        r_rr_ptr <= (r_grant == PORT_TAG_W'(N_PORT - 1)) ? '0 : r_grant + 1'b1;
      end
    end
  end

  // Downstream AW/W: payload always follows the granted lane; valids gate it.
  always_comb begin
    m.aw_valid[0]  = w_aw_valid;
    m.aw_id[0]     = {r_grant, s.aw_id[w_gsel]};
    m.aw_addr[0]   = s.aw_addr[w_gsel];
    m.aw_len[0]    = s.aw_len[w_gsel];
    m.aw_size[0]   = s.aw_size[w_gsel];
    m.aw_burst[0]  = s.aw_burst[w_gsel];
    m.aw_lock[0]   = s.aw_lock[w_gsel];
    m.aw_cache[0]  = s.aw_cache[w_gsel];
    m.aw_prot[0]   = s.aw_prot[w_gsel];
    m.aw_qos[0]    = s.aw_qos[w_gsel];
    m.aw_region[0] = s.aw_region[w_gsel];
    m.aw_user[0]   = s.aw_user[w_gsel];
    m.w_valid[0]   = w_w_valid;
    m.w_data[0]    = s.w_data[w_gsel];
    m.w_strb[0]    = s.w_strb[w_gsel];
    m.w_last[0]    = s.w_last[w_gsel];
    m.w_user[0]    = s.w_user[w_gsel];
  end

  // B responses are routed by the tag in the top ID bits; unknown tags are sunk.
  assign w_b_port = m.b_id[0][ID_WIDTH+PORT_TAG_W-1:ID_WIDTH];
  assign w_b_sel  = w_b_port[SEL_W-1:0];
  assign w_b_hit  = ({1'b0, w_b_port} < 4'(N_PORT));
  assign m.b_ready[0] = w_b_hit ? s.b_ready[w_b_sel] : 1'b1;

  always_comb begin
    s.aw_ready = '0;
    s.w_ready  = '0;
    s.b_valid  = '0;
    s.b_id     = '0;
    s.b_resp   = '0;
    s.b_user   = '0;
    for (int i = 0; i < N_PORT; i++) begin
      s.aw_ready[i] = (r_state == ST_ADDR) && (r_grant == PORT_TAG_W'(i)) && m.aw_ready[0];
      s.w_ready[i]  = (r_state == ST_DATA) && (r_grant == PORT_TAG_W'(i)) && m.w_ready[0];
      s.b_valid[i]  = m.b_valid[0] && w_b_hit && (w_b_port == PORT_TAG_W'(i));
      s.b_id[i]     = m.b_id[0][ID_WIDTH-1:0];
      s.b_resp[i]   = m.b_resp[0];
      s.b_user[i]   = m.b_user[0];
    end
  end

  // Read channels are not arbitrated here.
  assign s.ar_ready = '0;
  assign s.r_id     = '0;
  assign s.r_data   = '0;
  assign s.r_resp   = '0;
  assign s.r_last   = '0;
  assign s.r_valid  = '0;
  assign m.ar_id    = '0;
  assign m.ar_addr  = '0;
  assign m.ar_len   = '0;
  assign m.ar_valid = '0;
  assign m.r_ready  = '0;

  assign w_unused = ^{s.ar_id, s.ar_addr, s.ar_len, s.ar_valid, s.r_ready,
                      m.ar_ready, m.r_id, m.r_data, m.r_resp, m.r_last,
                      m.r_valid, 4'(MAX_OUTSTANDING)};

  assign o_dbg_state  = r_state;
  assign o_dbg_grant  = r_grant;
  assign o_dbg_rr_ptr = r_rr_ptr;

endmodule

// File: tb/tb_nasti_wr_arbiter.sv
// Directed self-checking bench for nasti_wr_arbiter (two requester ports).
module tb_nasti_wr_arbiter;
  import nasti_wr_arbiter_pkg::*;

  localparam int N_PORT          = 2;
  localparam int ID_WIDTH        = 1;
  localparam int ADDR_WIDTH      = 8;
  localparam int DATA_WIDTH      = 8;
  localparam int USER_WIDTH      = 1;
  localparam int MAX_OUTSTANDING = 2;
  localparam int MID_W           = ID_WIDTH + PORT_TAG_W;

  logic       clk;
  logic       rst;
  arb_state_e dbg_state;
  logic [2:0] dbg_grant;
  logic [2:0] dbg_rr_ptr;

  int         n_checks;
  int         n_errors;
  logic [2:0] exp_q[$];
  logic [2:0] exp_g;
  logic [2:0] last_g;

  nasti_channel #(.N_CHAN(N_PORT), .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
                  .DATA_WIDTH(DATA_WIDTH), .USER_WIDTH(USER_WIDTH)) s_if ();
  nasti_channel #(.N_CHAN(1), .ID_WIDTH(MID_W), .ADDR_WIDTH(ADDR_WIDTH),
                  .DATA_WIDTH(DATA_WIDTH), .USER_WIDTH(USER_WIDTH)) m_if ();

  nasti_wr_arbiter #(
    .N_PORT(N_PORT), .ID_WIDTH(ID_WIDTH), .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH), .USER_WIDTH(USER_WIDTH),
    .MAX_OUTSTANDING(MAX_OUTSTANDING)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s            (s_if),
    .m            (m_if),
    .o_dbg_state  (dbg_state),
    .o_dbg_grant  (dbg_grant),
    .o_dbg_rr_ptr (dbg_rr_ptr)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    s_if.aw_id = '0; s_if.aw_addr = '0; s_if.aw_len = '0; s_if.aw_size = '0;
    s_if.aw_burst = '0; s_if.aw_lock = '0; s_if.aw_cache = '0; s_if.aw_prot = '0;
    s_if.aw_qos = '0; s_if.aw_region = '0; s_if.aw_user = '0; s_if.aw_valid = '0;
    s_if.w_data = '0; s_if.w_strb = '0; s_if.w_last = '0; s_if.w_user = '0;
    s_if.w_valid = '0; s_if.b_ready = '0;
    s_if.ar_id = '0; s_if.ar_addr = '0; s_if.ar_len = '0; s_if.ar_valid = '0;
    s_if.r_ready = '0;
    m_if.aw_ready = '0; m_if.w_ready = '0;
    m_if.b_id = '0; m_if.b_resp = '0; m_if.b_user = '0; m_if.b_valid = '0;
    m_if.ar_ready = '0;
    m_if.r_id = '0; m_if.r_data = '0; m_if.r_resp = '0; m_if.r_last = '0;
    m_if.r_valid = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Single-beat burst on port 0, starting and ending in IDLE.
  task automatic burst0();
    s_if.aw_valid[0] = 1'b1;
    s_if.w_valid[0]  = 1'b1;
    s_if.w_last[0]   = 1'b1;
    m_if.aw_ready    = 1'b1;
    m_if.w_ready     = 1'b1;
    step();
    check("burst_addr_state", 32'(dbg_state), 32'(ST_ADDR));
    step();
    s_if.aw_valid[0] = 1'b0;
    step();
    s_if.w_valid[0]  = 1'b0;
    s_if.w_last[0]   = 1'b0;
    check("burst_idle_state", 32'(dbg_state), 32'(ST_IDLE));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    last_g   = '0;
    rst      = 1'b1;

    // Reset state, with downstream readies high so output gating is visible
    do_reset();
    m_if.aw_ready = 1'b1;
    m_if.w_ready  = 1'b1;
    #1;
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("rst_rr_ptr", 32'(dbg_rr_ptr), 32'd0);
    check("rst_grant", 32'(dbg_grant), 32'd0);
    check("rst_m_aw_valid", 32'(m_if.aw_valid), 32'd0);
    check("rst_m_w_valid", 32'(m_if.w_valid), 32'd0);
    check("rst_s_aw_ready", 32'(s_if.aw_ready), 32'd0);
    check("rst_s_w_ready", 32'(s_if.w_ready), 32'd0);

    // Single port: port0 AW addr 0x10 len 3, four W beats
    m_if.aw_ready    = 1'b0;
    s_if.aw_valid[0] = 1'b1;
    s_if.aw_id[0]    = 1'b1;
    s_if.aw_addr[0]  = 8'h10;
    s_if.aw_len[0]   = 8'd3;
    #1;
    check("t1_aw_latency", 32'(m_if.aw_valid), 32'd0);
    step();
    check("t1_state_addr", 32'(dbg_state), 32'(ST_ADDR));
    check("t1_m_aw_valid", 32'(m_if.aw_valid), 32'd1);
    check("t1_m_aw_id", 32'(m_if.aw_id[0]), 32'h1);
    check("t1_m_aw_addr", 32'(m_if.aw_addr[0]), 32'h10);
    check("t1_m_aw_len", 32'(m_if.aw_len[0]), 32'd3);
    check("t1_s_aw_ready_lo", 32'(s_if.aw_ready), 32'd0);
    m_if.aw_ready = 1'b1;
    #1;
    check("t1_s_aw_ready_hi", 32'(s_if.aw_ready), 32'b01);
    step();
    s_if.aw_valid[0] = 1'b0;
    m_if.aw_ready    = 1'b0;
    check("t1_state_data", 32'(dbg_state), 32'(ST_DATA));
    check("t1_rr_ptr", 32'(dbg_rr_ptr), 32'd1);
    for (int k = 0; k < 4; k++) begin
      s_if.w_valid[0] = 1'b1;
      s_if.w_data[0]  = 8'(8'hA0 + k);
      s_if.w_last[0]  = (k == 3);
      #1;
      check("t1_m_w_valid", 32'(m_if.w_valid), 32'd1);
      check("t1_m_w_data", 32'(m_if.w_data[0]), 32'hA0 + 32'(k));
      check("t1_m_w_last", 32'(m_if.w_last[0]), (k == 3) ? 32'd1 : 32'd0);
      step();
    end
    s_if.w_valid = '0;
    s_if.w_last  = '0;
    check("t1_back_idle", 32'(dbg_state), 32'(ST_IDLE));
    check("t1_m_w_valid_off", 32'(m_if.w_valid), 32'd0);

    // Round-robin: both ports request single-beat bursts continuously
    do_reset();
    s_if.aw_valid  = 2'b11;
    s_if.w_valid   = 2'b11;
    s_if.w_last    = 2'b11;
    s_if.w_data[0] = 8'h50;
    s_if.w_data[1] = 8'h51;
    m_if.aw_ready  = 1'b1;
    m_if.w_ready   = 1'b1;
    exp_q = {3'd0, 3'd1, 3'd0, 3'd1};
    for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
      if (dbg_state == ST_ADDR) begin
        exp_g  = exp_q.pop_front();
        check("rr_grant", 32'(m_if.aw_id[0][MID_W-1:ID_WIDTH]), 32'(exp_g));
        last_g = exp_g;
      end else if (dbg_state == ST_DATA && m_if.w_valid[0]) begin
        check("rr_w_data", 32'(m_if.w_data[0]), 32'h50 + 32'(last_g));
      end
      step();
    end
    check("rr_all_granted", 32'(exp_q.size()), 32'd0);

    // W isolation: port1 offers W beats while port0 owns the data phase
    do_reset();
    s_if.aw_valid = 2'b11;
    s_if.w_valid  = 2'b10;
    s_if.w_last   = 2'b11;
    m_if.aw_ready = 1'b1;
    m_if.w_ready  = 1'b1;
    #1;
    check("iso_idle_w_ready", 32'(s_if.w_ready), 32'd0);
    step();
    check("iso_addr0_w_ready", 32'(s_if.w_ready), 32'd0);
    check("iso_addr0_aw_ready", 32'(s_if.aw_ready), 32'b01);
    step();
    s_if.aw_valid = 2'b10;
    check("iso_data0_w_ready", 32'(s_if.w_ready), 32'b01);
    check("iso_data0_m_w_valid", 32'(m_if.w_valid), 32'd0);
    s_if.w_valid = 2'b11;
    #1;
    check("iso_data0_beat", 32'(m_if.w_valid), 32'd1);
    step();
    s_if.w_valid = 2'b10;
    check("iso_idle_after0", 32'(dbg_state), 32'(ST_IDLE));
    step();
    check("iso_addr1_grant", 32'(m_if.aw_id[0][MID_W-1:ID_WIDTH]), 32'd1);
    check("iso_addr1_w_ready", 32'(s_if.w_ready), 32'd0);
    step();
    s_if.aw_valid = 2'b00;
    check("iso_data1_w_ready", 32'(s_if.w_ready), 32'b10);
    check("iso_data1_m_w_valid", 32'(m_if.w_valid), 32'd1);
    step();
    s_if.w_valid = '0;
    check("iso_end_idle", 32'(dbg_state), 32'(ST_IDLE));

    // B steering: tag 1 with backpressure, then an out-of-range tag
    do_reset();
    m_if.b_valid   = 1'b1;
    m_if.b_id[0]   = 4'b0011;
    m_if.b_resp[0] = 2'b10;
    s_if.b_ready   = 2'b00;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("b_valid_lane1", 32'(s_if.b_valid), 32'b10);
      check("b_ready_held", 32'(m_if.b_ready), 32'd0);
      step();
    end
    s_if.b_ready = 2'b10;
    #1;
    check("b_id_lane1", 32'(s_if.b_id[1]), 32'd1);
    check("b_resp_lane1", 32'(s_if.b_resp[1]), 32'b10);
    check("b_ready_4th", 32'(m_if.b_ready), 32'd1);
    step();
    s_if.b_ready = 2'b00;
    m_if.b_id[0] = 4'b1010;
    #1;
    check("b_drop_valid", 32'(s_if.b_valid), 32'd0);
    check("b_drop_ready", 32'(m_if.b_ready), 32'd1);
    m_if.b_valid = 1'b0;

    // Outstanding-burst limit on port 0
    do_reset();
    burst0();
    burst0();
    s_if.aw_valid[0] = 1'b1;
`ifdef NASTI_WR_ARB_OUTSTANDING_EN
    for (int c = 0; c < 3; c++) begin
      step();
      check("os_blocked", 32'(dbg_state), 32'(ST_IDLE));
    end
    m_if.b_valid = 1'b1;
    m_if.b_id[0] = 4'b0000;
    s_if.b_ready = 2'b01;
    #1;
    check("os_b_ready", 32'(m_if.b_ready), 32'd1);
    step();
    m_if.b_valid = 1'b0;
    s_if.b_ready = 2'b00;
    check("os_still_idle", 32'(dbg_state), 32'(ST_IDLE));
    step();
    check("os_granted", 32'(dbg_state), 32'(ST_ADDR));
`else
    step();
    check("os_unlimited", 32'(dbg_state), 32'(ST_ADDR));
`endif
    s_if.aw_valid = '0;

    // Reset in DATA after 2 of 4 beats
    do_reset();
    s_if.aw_valid[0] = 1'b1;
    s_if.aw_len[0]   = 8'd3;
    m_if.aw_ready    = 1'b1;
    m_if.w_ready     = 1'b1;
    step();
    step();
    s_if.aw_valid[0] = 1'b0;
    s_if.w_valid[0]  = 1'b1;
    s_if.w_last[0]   = 1'b0;
    step();
    step();
    check("mid_state_data", 32'(dbg_state), 32'(ST_DATA));
    check("mid_rr_ptr", 32'(dbg_rr_ptr), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_w_valid", 32'(m_if.w_valid), 32'd0);
    check("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    check("mid_rst_rr_ptr", 32'(dbg_rr_ptr), 32'd0);
    check("mid_rst_w_ready", 32'(s_if.w_ready), 32'd0);

    // Final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/nasti_wr_arbiter.md
# nasti_wr_arbiter

- Round-robin arbiter sharing one NASTI write path (AW, W, B) among up to 8 requesters.
- Sits upstream of a demultiplexer or a single slave, where several masters converge on one port.
- Serialises write bursts: one AW is granted, that port's W beats are forwarded until w_last, then the next requester is arbitrated.
- B responses are steered back by a port tag carried in the upper ID bits.

## Interface
- N_PORT, 2: number of requester ports, 1..8.
- ID_WIDTH, 1: requester-side ID width; the downstream ID width is ID_WIDTH+3.
- ADDR_WIDTH, 8: address width.
- DATA_WIDTH, 8: data width.
- USER_WIDTH, 1: user field width, must be >0.
- MAX_OUTSTANDING, 4: per-port outstanding-burst limit, 1..15; used only with NASTI_WR_ARB_OUTSTANDING_EN.
- clk  input  1  single clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- s  nasti_channel.slave  N_PORT lanes  requester AW/W/B channels, lane i = port i; AR/R unused, readies tied 0.
- m  nasti_channel.master  lane 0  downstream AW/W/B channels, ID width ID_WIDTH+3.

## Operation
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - Eligible set = {i : s.aw_valid[i]} (masked per Configuration).
  - Winner = first eligible index at or after rr_ptr, wrapping modulo N_PORT.
  - Register winner in grant; go to ADDR. No eligible port: stay in IDLE.
- ADDR:
  - m.aw_valid=1; all AW fields come from s lane grant.
  - m.aw_id = {grant[2:0], s.aw_id[grant]}.
  - s.aw_ready[grant] = m.aw_ready; all other s.aw_ready = 0.
  - On m.aw_valid && m.aw_ready: go to DATA; rr_ptr <= (grant+1) mod N_PORT.
  - grant never changes while in ADDR, so AXI valid stability holds.
- DATA:
  - m.w_* = s lane grant; m.w_valid = s.w_valid[grant].
  - s.w_ready[grant] = m.w_ready; all other s.w_ready = 0.
  - On a w_last handshake: go to IDLE.
- W beats presented by any port before its AW is accepted are held off (w_ready=0).
- B path (independent of the FSM, combinational):
  - p = m.b_id[ID_WIDTH+2:ID_WIDTH].
  - s.b_valid[p] = m.b_valid; s.b_id[p] = m.b_id[ID_WIDTH-1:0]; s.b_resp/b_user[p] pass through.
  - m.b_ready = s.b_ready[p].
  - p >= N_PORT: m.b_ready = 1 and the response is dropped.
- Reset:
  - State IDLE; rr_ptr=0; grant=0; counters=0.
  - m.aw_valid=0, m.w_valid=0; all s.aw_ready=0, all s.w_ready=0.
  - Reset mid-burst abandons the burst; no W beat is forwarded in the cycle after reset.

## Timing
- s.aw_valid rising in IDLE -> m.aw_valid asserted next cycle (1-cycle arbitration latency).
- AW handshake in cycle t -> first W beat can be forwarded in t+1.
- W path is combinational, zero added latency; one beat per cycle at full throughput.
- Last W handshake in t -> IDLE in t+1 -> next m.aw_valid in t+2. Minimum burst overhead is 2 idle W cycles.
- B path is combinational, zero latency.

## Configuration
- NASTI_WR_ARB_OUTSTANDING_EN defined:
  - Per-port 4-bit counter: +1 on that port's AW handshake, -1 on that port's B handshake; unchanged when both occur in the same cycle.
  - Ports with counter == MAX_OUTSTANDING are excluded from the eligible set.
  - Counter never wraps; a B handshake at 0 leaves it at 0.
- Undefined: no counters; unlimited outstanding bursts; eligibility is s.aw_valid only.

## Structure
- Shared nasti package:
  - Port-tag width constant (3).
  - FSM state enum.
  - Round-robin helper function: (request vector, pointer) -> winner index.
- One sub-module, nasti_rr_picker: combinational, 8-bit request vector plus 3-bit pointer -> 3-bit index and found flag; reusable by a future read arbiter.

## Test plan
- Single port: port0 AW addr=0x10 len=3, 4 W beats -> m.aw_id={3'd0,id}, m.aw_valid one cycle after s.aw_valid, 4 beats forwarded, w_last ends burst, FSM back in IDLE.
- Round-robin: ports 0 and 1 request continuously with rr_ptr=0 -> grants alternate 0,1,0,1; no port granted twice consecutively while the other waits.
- W isolation: port1 drives w_valid while port0 owns DATA -> s.w_ready[1]=0 until port1 is granted and its AW accepted.
- B steering: m.b_id={3'd1,1'b1}, b_valid with s.b_ready[1]=0 for 3 cycles -> s.b_valid[1]=1 only on lane 1, m.b_ready=0 until the 4th cycle; m.b_id tag 3'd5 with N_PORT=2 -> m.b_ready=1, dropped.
- Outstanding limit (macro on, MAX_OUTSTANDING=2): port0 issues 2 bursts with no B -> third AW is not granted; one B returns -> granted next IDLE.
- Reset in DATA after 2 of 4 beats: rst high one cycle -> m.w_valid=0, state IDLE, rr_ptr=0 the following cycle.
